// File: rtl/vend_pkg.sv
// Shared types and constants for the vending dispense sequencer.
package vend_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_SODA_PULSE = 3'd1,
      ST_SODA_WAIT  = 3'd2,
      ST_COIN_PULSE = 3'd3,
      ST_COIN_WAIT  = 3'd4,
      ST_DONE       = 3'd5,
      ST_FAULT      = 3'd6
   } dispense_state_e;

   typedef enum logic [1:0] {
      FC_NONE    = 2'b00,
      FC_SODA_TO = 2'b01,
      FC_COIN_TO = 2'b10
   } fault_code_e;

   localparam int NICKEL_CENTS = 5;

   // Timer must hold the larger of the pulse width and the ack window, plus headroom to saturate.
   function automatic int timer_width(input int pulse_cycles, input int ack_timeout);
      return $clog2((pulse_cycles > ack_timeout) ? pulse_cycles : ack_timeout) + 1;
   endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Vend request, sensor feedback and actuator/status signals between the vending FSM, actuators and the sequencer.
interface vend_dispense_ctrl_if #(
   parameter int CHG_W = 3
);
   // Handshake: vend_valid_i is a 1-cycle strobe, accepted only when busy_o is low (busy_o acts as not-ready);
   // a strobe while busy_o is high is dropped, never queued.
   logic             vend_valid_i;
   logic             soda_i;
   logic [CHG_W-1:0] change_i;
   logic             soda_done_i;
   logic             nickel_done_i;
   logic             clear_fault_i;
   logic             busy_o;
   logic             soda_pulse_o;
   logic             nickel_pulse_o;
   logic [CHG_W-1:0] dispensed_o;
   logic             done_o;
   logic             fault_o;
   logic [1:0]       fault_code_o;

   modport master (
      output vend_valid_i, soda_i, change_i, soda_done_i, nickel_done_i, clear_fault_i,
      input  busy_o, soda_pulse_o, nickel_pulse_o, dispensed_o, done_o, fault_o, fault_code_o
   );

   modport slave (
      input  vend_valid_i, soda_i, change_i, soda_done_i, nickel_done_i, clear_fault_i,
      output busy_o, soda_pulse_o, nickel_pulse_o, dispensed_o, done_o, fault_o, fault_code_o
   );

endinterface

// File: rtl/vend_pulse_timer.sv
// Saturating up-counter with synchronous clear and a terminal-count compare, reused for pulse and wait phases.
module vend_pulse_timer #(
   parameter int W = 9
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         en_i,
   input  logic [W-1:0] tc_val_i,
   output logic         tc_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (en_i && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc_o = (count_q == tc_val_i);

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: soda chute pulse first, then one nickel pulse per coin owed, with ack timeouts latched as faults.
module vend_dispense_ctrl
   import vend_pkg::*;
#(
   parameter int PULSE_CYCLES = 4,
   parameter int ACK_TIMEOUT  = 255,
   parameter int CHG_W        = 3,
   parameter int MAX_CHANGE   = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   vend_dispense_ctrl_if.slave bus,
   output dispense_state_e    state_o
);

   localparam int               TW       = timer_width(PULSE_CYCLES, ACK_TIMEOUT);
   localparam logic [TW-1:0]    PULSE_TC = TW'(PULSE_CYCLES - 1);
   localparam logic [TW-1:0]    WAIT_TC  = TW'(ACK_TIMEOUT - 1);
   localparam logic [CHG_W-1:0] MAX_CHG  = CHG_W'(MAX_CHANGE);

   dispense_state_e  state_q, state_d;
   fault_code_e      fault_q, fault_d;
   logic [CHG_W-1:0] rem_q, rem_d;
   logic [CHG_W-1:0] disp_q, disp_d;
   logic             soda_sticky_q, soda_sticky_d;
   logic             nick_sticky_q, nick_sticky_d;

   logic [CHG_W-1:0] clamp_chg;
   logic [TW-1:0]    tc_val;
   logic             timer_tc;
   logic             timer_clear;
   logic             soda_ack;
   logic             nick_ack;

   vend_pulse_timer #(.W(TW)) u_timer (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .clear_i  (timer_clear),
      .en_i     (1'b1),
      .tc_val_i (tc_val),
      .tc_o     (timer_tc)
   );

   always_comb begin
      state_d       = state_q;
      fault_d       = fault_q;
      rem_d         = rem_q;
      disp_d        = disp_q;
      clamp_chg     = (bus.change_i > MAX_CHG) ? MAX_CHG : bus.change_i;
      tc_val        = ((state_q == ST_SODA_WAIT) || (state_q == ST_COIN_WAIT)) ? WAIT_TC : PULSE_TC;
      // An ack arriving while the solenoid is still driven is remembered and honoured on the first wait cycle.
      soda_sticky_d = (state_q == ST_SODA_PULSE) ? (soda_sticky_q | bus.soda_done_i) : 1'b0;
      nick_sticky_d = (state_q == ST_COIN_PULSE) ? (nick_sticky_q | bus.nickel_done_i) : 1'b0;
      soda_ack      = bus.soda_done_i | soda_sticky_q;
      nick_ack      = bus.nickel_done_i | nick_sticky_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.vend_valid_i) begin
               rem_d  = clamp_chg;
               disp_d = '0;
               if (bus.soda_i)              state_d = ST_SODA_PULSE;
               else if (clamp_chg != '0)    state_d = ST_COIN_PULSE;
               else                         state_d = ST_DONE;
            end
         end
         ST_SODA_PULSE: begin
            if (timer_tc) state_d = ST_SODA_WAIT;
         end
         ST_SODA_WAIT: begin
            if (soda_ack) begin
               state_d = (rem_q != '0) ? ST_COIN_PULSE : ST_DONE;
            end else if (timer_tc) begin
               state_d = ST_FAULT;
               fault_d = FC_SODA_TO;
            end
         end
         ST_COIN_PULSE: begin
            if (timer_tc) state_d = ST_COIN_WAIT;
         end
         ST_COIN_WAIT: begin
            if (nick_ack) begin
               disp_d  = disp_q + CHG_W'(1);
               rem_d   = rem_q - CHG_W'(1);
               state_d = (rem_q == CHG_W'(1)) ? ST_DONE : ST_COIN_PULSE;
            end else if (timer_tc) begin
               state_d = ST_FAULT;
               fault_d = FC_COIN_TO;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         ST_FAULT: begin
            if (bus.clear_fault_i) begin
               state_d = ST_IDLE;
               fault_d = FC_NONE;
               disp_d  = '0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      timer_clear = (state_d != state_q);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ST_IDLE;
         fault_q       <= FC_NONE;
         rem_q         <= '0;
         disp_q        <= '0;
         soda_sticky_q <= 1'b0;
         nick_sticky_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         fault_q       <= fault_d;
         rem_q         <= rem_d;
         disp_q        <= disp_d;
         soda_sticky_q <= soda_sticky_d;
         nick_sticky_q <= nick_sticky_d;
      end
   end

   assign bus.busy_o         = (state_q != ST_IDLE);
   assign bus.soda_pulse_o   = (state_q == ST_SODA_PULSE);
   assign bus.nickel_pulse_o = (state_q == ST_COIN_PULSE);
   assign bus.dispensed_o    = disp_q;
   assign bus.done_o         = (state_q == ST_DONE);
   assign bus.fault_o        = (state_q == ST_FAULT);
   assign bus.fault_code_o   = fault_q;
   assign state_o            = state_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Directed bench for vend_dispense_ctrl: clean vends, clamping, sticky acks, timeout boundaries, fault clear, reset abort.
module tb_vend_dispense_ctrl;
   import vend_pkg::*;

   logic            clk;
   logic            rst;
   dispense_state_e state;

   int n_tests;
   int n_fail;

   // Results recorded by run_vend
   int cyc, soda_n, nick_n, width_bad, done_n, done_cyc, idle_cyc, fault_cyc, last_n_fall;
   logic first_soda, first_nick;
   logic [2:0] first_disp;

   vend_dispense_ctrl_if #(.CHG_W(3)) vif ();

   vend_dispense_ctrl #(
      .PULSE_CYCLES (4),
      .ACK_TIMEOUT  (255),
      .CHG_W        (3),
      .MAX_CHANGE   (4)
   ) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .bus     (vif),
      .state_o (state)
   );

   // Clock / watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] outs();
      return {22'd0, vif.busy_o, vif.soda_pulse_o, vif.nickel_pulse_o, vif.dispensed_o,
              vif.done_o, vif.fault_o, vif.fault_code_o};
   endfunction

   // Strobe a vend, then act as both sensors: ack ack_dly cycles after each pulse ends.
   // Only the first nack_lim nickels are acknowledged. poke_c injects a strobe while busy.
   task automatic run_vend(input logic soda, input logic [2:0] chg, input int ack_dly,
                           input int nack_lim, input int poke_c, input int budget);
      int s_run, n_run, s_wait, n_wait;
      logic finished;
      s_run = 0; n_run = 0; s_wait = -1; n_wait = -1; finished = 1'b0;
      cyc = 0; soda_n = 0; nick_n = 0; width_bad = 0; done_n = 0;
      done_cyc = -1; idle_cyc = -1; fault_cyc = -1; last_n_fall = -1;
      vif.vend_valid_i = 1'b1;
      vif.soda_i       = soda;
      vif.change_i     = chg;
      for (int c = 0; c < budget; c++) begin
         tick();
         cyc++;
         vif.vend_valid_i  = 1'b0;
         vif.soda_done_i   = 1'b0;
         vif.nickel_done_i = 1'b0;
         if (c == poke_c) begin
            vif.vend_valid_i = 1'b1;
            vif.soda_i       = 1'b1;
            vif.change_i     = 3'd4;
         end
         if (cyc == 1) begin
            first_soda = vif.soda_pulse_o;
            first_nick = vif.nickel_pulse_o;
            first_disp = vif.dispensed_o;
         end
         if (vif.soda_pulse_o) s_run++;
         else if (s_run > 0) begin
            soda_n++;
            if (s_run != 4) width_bad++;
            s_run  = 0;
            s_wait = 0;
         end
         if (vif.nickel_pulse_o) n_run++;
         else if (n_run > 0) begin
            nick_n++;
            if (n_run != 4) width_bad++;
            n_run       = 0;
            last_n_fall = cyc;
            if (nick_n <= nack_lim) n_wait = 0;
         end
         if (s_wait >= 0) begin
            if (s_wait == ack_dly) begin vif.soda_done_i = 1'b1; s_wait = -1; end
            else s_wait++;
         end
         if (n_wait >= 0) begin
            if (n_wait == ack_dly) begin vif.nickel_done_i = 1'b1; n_wait = -1; end
            else n_wait++;
         end
         if (vif.done_o) begin done_n++; done_cyc = cyc; end
         if (vif.fault_o) begin fault_cyc = cyc; finished = 1'b1; break; end
         if (!vif.busy_o) begin idle_cyc = cyc; finished = 1'b1; break; end
      end
      vif.vend_valid_i  = 1'b0;
      vif.soda_done_i   = 1'b0;
      vif.nickel_done_i = 1'b0;
      chk("run_finished_in_budget", finished, 1'b1);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1;
      vif.vend_valid_i = 1'b0; vif.soda_i = 1'b0; vif.change_i = 3'd0;
      vif.soda_done_i = 1'b0; vif.nickel_done_i = 1'b0; vif.clear_fault_i = 1'b0;
      repeat (3) tick();
      chk("reset_outputs", outs(), 32'd0);
      chk("reset_state", 32'(state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();
      chk("idle_after_reset", outs(), 32'd0);

      // soda + 3 nickels, sensors ack 2 cycles after each pulse
      run_vend(1'b1, 3'd3, 2, 99, -1, 500);
      chk("s3_first_soda_latency", first_soda, 1'b1);
      chk("s3_first_disp", first_disp, 3'd0);
      chk("s3_soda_pulses", soda_n, 1);
      chk("s3_nickel_pulses", nick_n, 3);
      chk("s3_pulse_widths_bad", width_bad, 0);
      chk("s3_done_count", done_n, 1);
      chk("s3_idle_after_done", idle_cyc, done_cyc + 1);
      chk("s3_dispensed", vif.dispensed_o, 3'd3);
      chk("s3_no_fault", vif.fault_o, 1'b0);

      // nothing to dispense: DONE directly
      run_vend(1'b0, 3'd0, 2, 99, -1, 50);
      chk("z_done_cycle", done_cyc, 1);
      chk("z_idle_cycle", idle_cyc, 2);
      chk("z_no_pulses", soda_n + nick_n, 0);
      chk("z_dispensed", vif.dispensed_o, 3'd0);

      // change only
      run_vend(1'b0, 3'd2, 1, 99, -1, 500);
      chk("c2_first_nick_latency", first_nick, 1'b1);
      chk("c2_soda_pulses", soda_n, 0);
      chk("c2_nickel_pulses", nick_n, 2);
      chk("c2_dispensed", vif.dispensed_o, 3'd2);
      chk("c2_done_count", done_n, 1);

      // over-limit change clamps to 4
      run_vend(1'b0, 3'd7, 0, 99, -1, 500);
      chk("c7_nickel_pulses", nick_n, 4);
      chk("c7_dispensed", vif.dispensed_o, 3'd4);
      chk("c7_widths_bad", width_bad, 0);

      // strobe while busy is dropped
      run_vend(1'b0, 3'd1, 2, 99, 1, 500);
      chk("busy_poke_soda_pulses", soda_n, 0);
      chk("busy_poke_nickel_pulses", nick_n, 1);
      chk("busy_poke_dispensed", vif.dispensed_o, 3'd1);
      chk("busy_poke_idle", vif.busy_o, 1'b0);

      // second nickel never acknowledged -> coin timeout
      run_vend(1'b0, 3'd3, 2, 1, -1, 1000);
      chk("cto_fault", vif.fault_o, 1'b1);
      chk("cto_code", vif.fault_code_o, 2'b10);
      chk("cto_dispensed", vif.dispensed_o, 3'd1);
      chk("cto_nickel_pulses", nick_n, 2);
      chk("cto_wait_len", fault_cyc - last_n_fall, 255);
      chk("cto_pulses_low", {vif.soda_pulse_o, vif.nickel_pulse_o}, 2'b00);
      vif.vend_valid_i = 1'b1; vif.soda_i = 1'b1; vif.change_i = 3'd1;
      vif.nickel_done_i = 1'b1;
      tick();
      vif.vend_valid_i = 1'b0; vif.nickel_done_i = 1'b0;
      tick();
      chk("cto_vend_ignored", 32'(state), 32'(ST_FAULT));
      chk("cto_dispensed_frozen", vif.dispensed_o, 3'd1);
      vif.clear_fault_i = 1'b1;
      tick();
      vif.clear_fault_i = 1'b0;
      chk("cto_cleared_outputs", outs(), 32'd0);
      chk("cto_cleared_state", 32'(state), 32'(ST_IDLE));

      // soda ack during the pulse is held and consumed on the first wait cycle
      vif.soda_i = 1'b1; vif.change_i = 3'd0; vif.vend_valid_i = 1'b1;
      tick();
      vif.vend_valid_i = 1'b0;
      tick();
      vif.soda_done_i = 1'b1;
      tick();
      vif.soda_done_i = 1'b0;
      tick();
      chk("sticky_still_pulsing", vif.soda_pulse_o, 1'b1);
      tick();
      chk("sticky_wait_state", 32'(state), 32'(ST_SODA_WAIT));
      tick();
      chk("sticky_done", vif.done_o, 1'b1);
      tick();
      chk("sticky_idle", outs(), 32'd0);

      // ack on the last allowed wait cycle still wins over timeout
      vif.soda_i = 1'b1; vif.change_i = 3'd0; vif.vend_valid_i = 1'b1;
      for (int c = 1; c <= 259; c++) begin
         tick();
         vif.vend_valid_i = 1'b0;
      end
      chk("edge_still_waiting", 32'(state), 32'(ST_SODA_WAIT));
      vif.soda_done_i = 1'b1;
      tick();
      vif.soda_done_i = 1'b0;
      chk("edge_done", vif.done_o, 1'b1);
      chk("edge_no_fault", vif.fault_o, 1'b0);
      tick();
      chk("edge_idle", vif.busy_o, 1'b0);

      // soda never acknowledged -> soda timeout
      vif.soda_i = 1'b1; vif.change_i = 3'd2; vif.vend_valid_i = 1'b1;
      for (int c = 1; c <= 259; c++) begin
         tick();
         vif.vend_valid_i = 1'b0;
      end
      chk("sto_not_yet", vif.fault_o, 1'b0);
      tick();
      chk("sto_fault", vif.fault_o, 1'b1);
      chk("sto_code", vif.fault_code_o, 2'b01);
      chk("sto_dispensed", vif.dispensed_o, 3'd0);
      vif.clear_fault_i = 1'b1;
      tick();
      vif.clear_fault_i = 1'b0;
      chk("sto_cleared", outs(), 32'd0);

      // reset in the middle of a nickel pulse
      vif.soda_i = 1'b0; vif.change_i = 3'd2; vif.vend_valid_i = 1'b1;
      tick();
      vif.vend_valid_i = 1'b0;
      tick();
      chk("rst_mid_pulsing", vif.nickel_pulse_o, 1'b1);
      rst = 1'b1;
      tick();
      chk("rst_mid_outputs", outs(), 32'd0);
      chk("rst_mid_state", 32'(state), 32'(ST_IDLE));
      rst = 1'b0;
      tick();
      chk("rst_mid_stays_idle", outs(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
